// File: rtl/flex_rx_frame_sr.sv
// UART receive-frame shift register: collects DATA_BITS data bits, optional parity
// and 1-2 stop bits LSB-first, counts bits, and flags completion, parity and framing errors.
module flex_rx_frame_sr #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  localparam int unsigned FRAME_LEN = DATA_BITS + PARITY_EN + STOP_BITS,
  localparam int unsigned CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  input  logic                 clear,
  output logic [DATA_BITS-1:0] packet_data,
  output logic                 parity_bit,
  output logic [STOP_BITS-1:0] stop_bits,
  output logic [CW-1:0]        bit_count,
  output logic                 frame_done,
  output logic                 parity_error,
  output logic                 framing_error
);

  localparam logic PAR_ODD = 1'(PARITY_ODD);
  localparam logic PAR_EN  = (PARITY_EN != 0);

  logic [FRAME_LEN-1:0] sr;
  logic [FRAME_LEN-1:0] sr_next_c;
  logic                 par_next_c;
  logic                 par_calc_c;
  logic                 last_bit_c;

  // Contents of sr after the current strobe; errors are judged on the completed frame.
  always_comb begin
    sr_next_c  = {serial_in, sr[FRAME_LEN-1:1]};
    par_next_c = PAR_EN ? sr_next_c[DATA_BITS] : 1'b0;
    par_calc_c = (^sr_next_c[DATA_BITS-1:0]) ^ par_next_c;
    last_bit_c = (bit_count == CW'(FRAME_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr            <= '1;
      bit_count     <= '0;
      frame_done    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        sr        <= '1;
        bit_count <= '0;
      end else if (shift_strobe) begin
        sr <= sr_next_c;
        if (last_bit_c) begin
          bit_count     <= '0;
          frame_done    <= 1'b1;
          parity_error  <= PAR_EN && (par_calc_c != PAR_ODD);
          framing_error <= ~&sr_next_c[FRAME_LEN-1 -: STOP_BITS];
        end else begin
          bit_count <= bit_count + CW'(1);
        end
      end
    end
  end

  assign packet_data = sr[DATA_BITS-1:0];
  assign stop_bits   = sr[FRAME_LEN-1 -: STOP_BITS];

  generate
    if (PARITY_EN != 0) begin : g_par
      assign parity_bit = sr[DATA_BITS];
    end else begin : g_nopar
      assign parity_bit = 1'b0;
    end
  endgenerate

endmodule
